// File: rtl/latch_test_pkg.sv
// Shared types and constants for the latch/DFF cell test sequencer.
package latch_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic [7:0]  LFSR_TAPS  = 8'hB8;
  localparam int unsigned FAIL_CNT_W = 8;
  localparam int unsigned VEC_IDX_W  = 8;

endpackage

// File: rtl/lfsr8_step.sv
// One step of the 8-bit Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting left.
module lfsr8_step
  import latch_test_pkg::*;
(
  input  logic [7:0] lfsr_i,
  output logic [7:0] lfsr_o
);

  assign lfsr_o = {lfsr_i[6:0], ^(lfsr_i & LFSR_TAPS)};

endmodule

// File: rtl/latch_cell_test_sequencer.sv
// Drives setup/pulse/hold/sample vectors into a bank of storage cells and scores them.
// Optional first-failure capture ports are enabled by defining SEQ_FAIL_CAPTURE_EN.
module latch_cell_test_sequencer
  import latch_test_pkg::*;
#(
  parameter int unsigned NCELL     = 4,
  parameter int unsigned NVEC      = 16,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 1,
  parameter int unsigned HOLD_CYC  = 2,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [NCELL-1:0]      dut_q_i,
  output logic [NCELL-1:0]      dut_d_o,
  output logic                  dut_en_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [FAIL_CNT_W-1:0] fail_cnt_o,
  output logic [VEC_IDX_W-1:0]  vec_idx_o
`ifdef SEQ_FAIL_CAPTURE_EN
  ,
  output logic [VEC_IDX_W-1:0]  first_fail_idx_o,
  output logic [NCELL-1:0]      first_fail_mask_o
`endif
);

  localparam int unsigned PH_MAX0 = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned PH_MAX  = (PH_MAX0 > HOLD_CYC) ? PH_MAX0 : HOLD_CYC;
  localparam int unsigned PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  state_e                 state_q, state_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [7:0]             lfsr_q, lfsr_d, lfsr_nxt_c;
  logic [NCELL-1:0]       golden_q, golden_d;
  logic [NCELL-1:0]       dut_d_q, dut_d_d;
  logic                   dut_en_q, dut_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [FAIL_CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [VEC_IDX_W-1:0]   vec_idx_q, vec_idx_d;
`ifdef SEQ_FAIL_CAPTURE_EN
  logic [VEC_IDX_W-1:0]   ff_idx_q, ff_idx_d;
  logic [NCELL-1:0]       ff_mask_q, ff_mask_d;
`endif

  logic phase_last_c;
  logic mismatch_c;

  lfsr8_step u_lfsr (
    .lfsr_i (lfsr_q),
    .lfsr_o (lfsr_nxt_c)
  );

  assign phase_last_c = (phase_q == '0);
  assign mismatch_c   = (dut_q_i != golden_q);

  // Next-state and registered-output logic; abort overrides any busy state.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    lfsr_d     = lfsr_q;
    golden_d   = golden_q;
    dut_d_d    = dut_d_q;
    dut_en_d   = dut_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    fail_cnt_d = fail_cnt_q;
    vec_idx_d  = vec_idx_q;
`ifdef SEQ_FAIL_CAPTURE_EN
    ff_idx_d   = ff_idx_q;
    ff_mask_d  = ff_mask_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          state_d    = ST_SETUP;
          phase_d    = PH_W'(SETUP_CYC - 1);
          busy_d     = 1'b1;
          fail_cnt_d = '0;
          vec_idx_d  = '0;
          lfsr_d     = LFSR_SEED;
          dut_d_d    = LFSR_SEED[NCELL-1:0];
          dut_en_d   = 1'b0;
`ifdef SEQ_FAIL_CAPTURE_EN
          ff_idx_d   = '0;
          ff_mask_d  = '0;
`endif
        end
      end
      ST_SETUP: begin
        if (phase_last_c) begin
          state_d  = ST_PULSE;
          phase_d  = PH_W'(PULSE_CYC - 1);
          dut_en_d = 1'b1;
          golden_d = dut_d_q;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      ST_PULSE: begin
        if (phase_last_c) begin
          state_d  = ST_HOLD;
          phase_d  = PH_W'(HOLD_CYC - 1);
          dut_en_d = 1'b0;
          dut_d_d  = ~golden_q;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      ST_HOLD: begin
        if (phase_last_c) begin
          state_d = ST_SAMPLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (mismatch_c) begin
          fail_cnt_d = (fail_cnt_q == '1) ? fail_cnt_q : fail_cnt_q + FAIL_CNT_W'(1);
`ifdef SEQ_FAIL_CAPTURE_EN
          // Counter still zero means this is the run's first mismatch.
          if (fail_cnt_q == '0) begin
            ff_idx_d  = vec_idx_q;
            ff_mask_d = dut_q_i ^ golden_q;
          end
`endif
        end
        lfsr_d = lfsr_nxt_c;
        if (vec_idx_q == VEC_IDX_W'(NVEC - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (fail_cnt_d == '0);
        end else begin
          state_d   = ST_SETUP;
          phase_d   = PH_W'(SETUP_CYC - 1);
          vec_idx_d = vec_idx_q + VEC_IDX_W'(1);
          dut_d_d   = lfsr_nxt_c[NCELL-1:0];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (abort_i && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      dut_en_d   = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      pass_d     = pass_q;
      fail_cnt_d = fail_cnt_q;
      vec_idx_d  = vec_idx_q;
      lfsr_d     = lfsr_q;
`ifdef SEQ_FAIL_CAPTURE_EN
      ff_idx_d   = ff_idx_q;
      ff_mask_d  = ff_mask_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      lfsr_q     <= LFSR_SEED;
      golden_q   <= '0;
      dut_d_q    <= '0;
      dut_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_cnt_q <= '0;
      vec_idx_q  <= '0;
`ifdef SEQ_FAIL_CAPTURE_EN
      ff_idx_q   <= '0;
      ff_mask_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      lfsr_q     <= lfsr_d;
      golden_q   <= golden_d;
      dut_d_q    <= dut_d_d;
      dut_en_q   <= dut_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_cnt_q <= fail_cnt_d;
      vec_idx_q  <= vec_idx_d;
`ifdef SEQ_FAIL_CAPTURE_EN
      ff_idx_q   <= ff_idx_d;
      ff_mask_q  <= ff_mask_d;
`endif
    end
  end

  assign dut_d_o    = dut_d_q;
  assign dut_en_o   = dut_en_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign fail_cnt_o = fail_cnt_q;
  assign vec_idx_o  = vec_idx_q;
`ifdef SEQ_FAIL_CAPTURE_EN
  assign first_fail_idx_o  = ff_idx_q;
  assign first_fail_mask_o = ff_mask_q;
`endif

endmodule
